// File: rtl/nibble_addsub_seq.sv
// -----------------------------------------------------------------------------
// nibble_addsub_seq
//
// Multi-cycle add/subtract sequencer. A single 4-bit carry-lookahead slice is
// reused over NIBBLES cycles. Each cycle it processes one nibble of the latched
// operands, least-significant nibble first. Subtraction is done as
// a + ~b + 1: the inverted B operand and a carry-in of 1 are latched when the
// operation is accepted.
//
// Ports:
//   clk     in  1  rising-edge clock
//   rst_n   in  1  synchronous, active-low reset
//   start   in  1  request pulse, accepted only while idle
//   op_sub  in  1  0 = a+b, 1 = a-b (sampled with start)
//   a       in  W  operand A (sampled with start)
//   b       in  W  operand B (sampled with start)
//   busy    out 1  high from the cycle after acceptance through the done cycle
//   done    out 1  one-cycle pulse, result/cout/ovf valid
//   result  out W  sum or difference, held until the next done
//   cout    out 1  final carry out (for subtract: 1 = no borrow)
//   ovf     out 1  two's-complement signed overflow
//
// W = 4*NIBBLES. The legal range for NIBBLES is 2..8.
// -----------------------------------------------------------------------------
module nibble_addsub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            cy_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic [W-1:0]    result_q;
    logic            busy_q;
    logic            done_q;
    logic            cout_q;
    logic            ovf_q;

    // Shared slice signals
    logic [IW+1:0]   nib_base;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_p;
    logic [3:0]      nib_g;
    logic            c1;
    logic            c2;
    logic            c3;
    logic            c4;
    logic [3:0]      nib_sum;

    // Carry-lookahead slice acting on the nibble selected by idx_q
    always_comb begin
        nib_base = {idx_q, 2'b00};
        nib_a    = opa_q[nib_base +: 4];
        nib_b    = opb_q[nib_base +: 4];
        nib_p    = nib_a ^ nib_b;
        nib_g    = nib_a & nib_b;
        c1 = nib_g[0] | (nib_p[0] & cy_q);
        c2 = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & cy_q);
        c3 = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
           | (nib_p[2] & nib_p[1] & nib_p[0] & cy_q);
        c4 = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
           | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
           | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & cy_q);
        nib_sum = nib_p ^ {c3, c2, c1, cy_q};
    end

    // Accumulator with the current nibble merged in. The result register loads
    // this value directly, so the final nibble is already included on the
    // RUN->DONE edge.
    always_comb begin
        acc_d = acc_q;
        acc_d[nib_base +: 4] = nib_sum;
    end

    // Sequencer FSM and all registered state/outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= op_sub ? ~b : b;
                        // The carry-in of 1 completes the two's complement of B
                        cy_q    <= op_sub;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cy_q  <= c4;
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= '0;
                        result_q <= acc_d;
                        cout_q   <= c4;
                        // Overflow: carry into the sign bit differs from carry out
                        ovf_q    <= c3 ^ c4;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        idx_q    <= idx_q + IW'(1);
                        state_q  <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // A start seen in this cycle is deliberately dropped
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_addsub_seq (NIBBLES = 4, 16-bit operands).
// Vector table of known cases, randomized operations checked against an
// integer-arithmetic reference model, and hand-written multi-cycle sequences
// covering start-while-busy and reset during RUN.
// -----------------------------------------------------------------------------
module tb_nibble_addsub_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total;
    int bad;

    nibble_addsub_seq #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] er;
        logic        eco;
        logic        eov;
        string       nm;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                         output logic [15:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, full, sres;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            full = ua - ub;
            co   = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub;
            co   = (full > 65535);
            sres = sa + sb;
        end
        r  = full[15:0];
        ov = (sres > 32767) || (sres < -32768);
    endtask

    // One complete operation with timing, hold and result checks.
    // Operands are scrambled right after acceptance to prove only latched
    // copies are used.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                          input logic [15:0] er, input logic eco, input logic eov,
                          input string nm);
        int cyc;
        int bcnt;
        logic [15:0] prev;
        prev = result;
        @(negedge clk);
        a = ta; b = tb_; op_sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
        cyc = 1;
        bcnt = 0;
        while (!done && cyc <= N + 3) begin
            if (busy) bcnt++;
            chk({nm, ":held"}, {16'd0, result}, {16'd0, prev});
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) bcnt++;
        chk({nm, ":done"}, {31'd0, done}, 32'd1);
        chk({nm, ":latency"}, cyc, N + 1);
        chk({nm, ":busy_cycles"}, bcnt, N + 1);
        chk({nm, ":result"}, {16'd0, result}, {16'd0, er});
        chk({nm, ":cout"}, {31'd0, cout}, {31'd0, eco});
        chk({nm, ":ovf"}, {31'd0, ovf}, {31'd0, eov});
        @(posedge clk); #1;
        chk({nm, ":done_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, ":busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, mr;
        logic        rs, mco, mov;
        int          cyc;
        logic [15:0] edge_vals [4];

        total = 0;
        bad   = 0;
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF;
        edge_vals[2] = 16'h8000; edge_vals[3] = 16'h7FFF;

        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add_chain"};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
        tbl[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow"};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
        tbl[5] = '{16'h0F0F, 16'h0101, 1'b1, 16'h0E0E, 1'b1, 1'b0, "sub_latched"};

        // Reset, with start held high that must be ignored
        rst_n = 1'b0; start = 1'b1; op_sub = 1'b0; a = 16'h1111; b = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:busy", {31'd0, busy}, 32'd0);
        chk("rst:done", {31'd0, done}, 32'd0);
        chk("rst:result", {16'd0, result}, 32'd0);
        chk("rst:cout", {31'd0, cout}, 32'd0);
        chk("rst:ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].va, tbl[i].vb, tbl[i].vsub, tbl[i].er, tbl[i].eco, tbl[i].eov, tbl[i].nm);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = (i % 5 == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            rb = (i % 7 == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, mr, mco, mov);
            run_op(ra, rb, rs, mr, mco, mov, "rand");
        end

        // Start while busy: at T2 and in the done cycle, both ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_start:done", {31'd0, done}, 32'd1);
        chk("busy_start:result", {16'd0, result}, 32'h2233);
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_start:ignored_in_done", {31'd0, busy}, 32'd0);
        chk("busy_start:no_done", {31'd0, done}, 32'd0);
        // start still high in IDLE: accepted on this edge
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc <= N + 3) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("restart:latency", cyc, N + 1);
        chk("restart:result", {16'd0, result}, 32'h0002);
        chk("restart:cout", {31'd0, cout}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of RUN
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("midrst:busy", {31'd0, busy}, 32'd0);
        chk("midrst:done", {31'd0, done}, 32'd0);
        chk("midrst:result", {16'd0, result}, 32'd0);
        chk("midrst:cout", {31'd0, cout}, 32'd0);
        chk("midrst:ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst:no_done", {31'd0, done}, 32'd0);
            chk("midrst:idle", {31'd0, busy}, 32'd0);
        end
        run_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
